// File: rtl/task_sequencer.sv
// task_sequencer: upstream sequencer for the recv/send/conv control block.
// The host loads a descriptor RAM while the block is idle. A start pulse walks
// descriptors 0..prog_len-1: each one is decoded into task enables plus a
// config word, announced with a task_valid pulse, and then the block waits for
// ap_done before fetching the next one. Illegal codes and hung tasks abort.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   prog_wr_en/addr/data         descriptor write port (idle only);
//                                data[2:0]={recv,send,conv}, data[CFG_W+2:3]=cfg
//   prog_len                     descriptor count, sampled on an accepted start
//   start                        start pulse, ignored unless idle
//   busy, done                   run status, one-cycle end-of-program pulse
//   err_illegal, err_timeout     sticky abort causes, cleared by next start
//   task_count                   tasks completed in the current/last run
//   task_valid                   one-cycle pulse per presented task
//   recv_enable, send_enable,
//   conv_start, task_cfg         current task, held between task_valid pulses
//   ap_done                      downstream completion level
module task_sequencer #(
   parameter int unsigned DEPTH     = 64,
   parameter int unsigned AW        = 6,
   parameter int unsigned CFG_W     = 29,
   parameter int unsigned GUARD_CYC = 2,
   parameter int unsigned TIMEOUT   = 32'd1048575
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             prog_wr_en,
   input  logic [AW-1:0]    prog_wr_addr,
   input  logic [CFG_W+2:0] prog_wr_data,
   input  logic [AW:0]      prog_len,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             err_illegal,
   output logic             err_timeout,
   output logic [AW:0]      task_count,
   output logic             task_valid,
   output logic             recv_enable,
   output logic             send_enable,
   output logic             conv_start,
   output logic [CFG_W-1:0] task_cfg,
   input  logic             ap_done
);

   localparam int unsigned DW = CFG_W + 3;
   localparam int unsigned GW = (GUARD_CYC > 0) ? $clog2(GUARD_CYC + 1) : 1;
   localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      StIdle, StFetch, StDecode, StIssue, StGuard, StWait, StFin
   } state_e;

   state_e         state_q;
   logic [AW:0]    ptr_q;
   logic [AW:0]    len_q;
   logic [GW-1:0]  guard_q;
   logic [WW-1:0]  wd_q;
   logic [DW-1:0]  mem [DEPTH];
   logic [DW-1:0]  rd_q;
   logic [2:0]     code;
   logic           legal;
   logic [AW:0]    ptr_inc;
   logic [AW:0]    len_clamped;

   assign code        = rd_q[2:0];
   assign legal       = (code == 3'b100) || (code == 3'b010) ||
                        (code == 3'b001) || (code == 3'b101);
   assign ptr_inc     = ptr_q + (AW+1)'(1);
   assign len_clamped = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
   assign busy        = (state_q != StIdle);

   // Descriptor RAM: write only while idle, registered read of the pointer so
   // the entry addressed in FETCH is available in DECODE.
   always_ff @(posedge clk) begin
      if (prog_wr_en && (state_q == StIdle)) begin
         mem[prog_wr_addr] <= prog_wr_data;
      end
      rd_q <= mem[ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         len_q       <= '0;
         guard_q     <= '0;
         wd_q        <= '0;
         done        <= 1'b0;
         err_illegal <= 1'b0;
         err_timeout <= 1'b0;
         task_count  <= '0;
         task_valid  <= 1'b0;
         recv_enable <= 1'b0;
         send_enable <= 1'b0;
         conv_start  <= 1'b0;
         task_cfg    <= '0;
      end else begin
         task_valid <= 1'b0;
         done       <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  err_illegal <= 1'b0;
                  err_timeout <= 1'b0;
                  task_count  <= '0;
                  len_q       <= len_clamped;
                  ptr_q       <= '0;
                  state_q     <= (len_clamped == '0) ? StFin : StFetch;
               end
            end
            StFetch: state_q <= StDecode;
            StDecode: begin
               if (legal) begin
                  {recv_enable, send_enable, conv_start} <= code;
                  task_cfg <= rd_q[DW-1:3];
                  state_q  <= StIssue;
               end else begin
                  // Enables keep the last legal task's values.
                  err_illegal <= 1'b1;
                  state_q     <= StFin;
               end
            end
            StIssue: begin
               task_valid <= 1'b1;
               guard_q    <= GW'(GUARD_CYC);
               wd_q       <= '0;
               state_q    <= (GUARD_CYC == 0) ? StWait : StGuard;
            end
            StGuard: begin
               // ap_done may still reflect the previous task here; ignore it.
               guard_q <= guard_q - GW'(1);
               wd_q    <= '0;
               if (guard_q <= GW'(1)) begin
                  state_q <= StWait;
               end
            end
            StWait: begin
               // ap_done has priority over a watchdog expiry in the same cycle.
               if (ap_done) begin
                  task_count <= task_count + (AW+1)'(1);
                  ptr_q      <= ptr_inc;
                  state_q    <= (ptr_inc == len_q) ? StFin : StFetch;
               end else if ((TIMEOUT != 0) && (wd_q == WW'(TIMEOUT - 1))) begin
                  err_timeout <= 1'b1;
                  state_q     <= StFin;
               end else begin
                  wd_q <= wd_q + WW'(1);
               end
            end
            StFin: begin
               done    <= 1'b1;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_task_sequencer.sv
module tb_task_sequencer;

   localparam int unsigned AW    = 6;
   localparam int unsigned CFG_W = 29;
   localparam int unsigned DW    = CFG_W + 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             prog_wr_en;
   logic [AW-1:0]    prog_wr_addr;
   logic [DW-1:0]    prog_wr_data;
   logic [AW:0]      prog_len;
   logic             start;
   logic             busy, done, err_illegal, err_timeout, task_valid;
   logic [AW:0]      task_count;
   logic             recv_enable, send_enable, conv_start;
   logic [CFG_W-1:0] task_cfg;
   logic             ap_done;

   int checks = 0;
   int errors = 0;

   // Scoreboard: expected {code, cfg} per task_valid pulse.
   logic [DW-1:0] exp_q [$];
   int  tv_count, done_count;
   time tv_first_t, done_t, t_start;
   time tv_times [$];

   // Downstream model: mode 0 never answers, 1 answers resp_delay cycles after
   // task_valid, 2 holds ap_done high permanently.
   int resp_mode  = 1;
   int resp_delay = 5;
   int resp_cnt;

   task_sequencer #(
      .DEPTH     (64),
      .AW        (AW),
      .CFG_W     (CFG_W),
      .GUARD_CYC (2),
      .TIMEOUT   (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .prog_wr_en   (prog_wr_en),
      .prog_wr_addr (prog_wr_addr),
      .prog_wr_data (prog_wr_data),
      .prog_len     (prog_len),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .err_illegal  (err_illegal),
      .err_timeout  (err_timeout),
      .task_count   (task_count),
      .task_valid   (task_valid),
      .recv_enable  (recv_enable),
      .send_enable  (send_enable),
      .conv_start   (conv_start),
      .task_cfg     (task_cfg),
      .ap_done      (ap_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ap_done  <= 1'b0;
         resp_cnt <= 0;
      end else if (resp_mode == 2) begin
         ap_done <= 1'b1;
      end else if (task_valid) begin
         ap_done  <= 1'b0;
         resp_cnt <= resp_delay;
      end else if (resp_cnt != 0) begin
         resp_cnt <= resp_cnt - 1;
         if (resp_cnt == 1 && resp_mode == 1) ap_done <= 1'b1;
      end
   end

   // Monitor: pop and compare one expected task on every task_valid pulse.
   always @(negedge clk) begin
      if (!rst) begin
         if (task_valid) begin
            tv_count++;
            tv_times.push_back($time);
            if (tv_first_t == 0) tv_first_t = $time;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected_task got %h exp none",
                        {recv_enable, send_enable, conv_start, task_cfg});
            end else begin
               logic [DW-1:0] e;
               e = exp_q.pop_front();
               if ({recv_enable, send_enable, conv_start, task_cfg} !== e) begin
                  errors++;
                  $display("FAIL sb_task got %h exp %h",
                           {recv_enable, send_enable, conv_start, task_cfg}, e);
               end
            end
         end
         if (done) begin
            done_count++;
            done_t = $time;
         end
      end
   end

   task automatic write_desc(input int addr, input logic [2:0] code,
                             input logic [CFG_W-1:0] cfg);
      prog_wr_en   = 1'b1;
      prog_wr_addr = AW'(addr);
      prog_wr_data = {cfg, code};
      @(posedge clk);
      #1 prog_wr_en = 1'b0;
   endtask

   task automatic clear_stats();
      tv_count   = 0;
      done_count = 0;
      tv_first_t = 0;
      done_t     = 0;
      tv_times.delete();
   endtask

   task automatic do_start(input int len);
      prog_len = (AW+1)'(len);
      start    = 1'b1;
      @(posedge clk);
      t_start = $time;
      #1 start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_done_wait got no done exp done within %0d cycles", name, budget);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({busy, done, err_illegal, err_timeout, task_valid} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got %b exp 00000",
                  {busy, done, err_illegal, err_timeout, task_valid});
      end
      checks++;
      if ({task_count, recv_enable, send_enable, conv_start, task_cfg} !== '0) begin
         errors++;
         $display("FAIL reset_task got %h exp 0",
                  {task_count, recv_enable, send_enable, conv_start, task_cfg});
      end
      @(posedge clk);
      #1 rst = 1'b0;
      idle(2);
   endtask

   task automatic test_basic();
      write_desc(0, 3'b100, 29'd5);
      write_desc(1, 3'b001, 29'd7);
      write_desc(2, 3'b010, 29'd9);
      exp_q.push_back({3'b100, 29'd5});
      exp_q.push_back({3'b001, 29'd7});
      exp_q.push_back({3'b010, 29'd9});
      resp_mode = 1;
      clear_stats();
      do_start(3);
      wait_done("basic", 200);
      idle(3);
      checks++;
      if (tv_first_t !== t_start + 35) begin
         errors++;
         $display("FAIL basic_first_latency got %0t exp %0t", tv_first_t - t_start, 35);
      end
      checks++;
      if (tv_count !== 3 || done_count !== 1) begin
         errors++;
         $display("FAIL basic_pulses got tv=%0d done=%0d exp tv=3 done=1", tv_count, done_count);
      end
      checks++;
      if (task_count !== 7'd3 || err_illegal !== 1'b0 || err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL basic_status got cnt=%0d ill=%b to=%b exp cnt=3 ill=0 to=0",
                  task_count, err_illegal, err_timeout);
      end
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL basic_sb_left got %0d exp 0", exp_q.size());
      end
   endtask

   task automatic test_stuck_done();
      exp_q.push_back({3'b100, 29'd5});
      exp_q.push_back({3'b001, 29'd7});
      exp_q.push_back({3'b010, 29'd9});
      resp_mode = 2;
      clear_stats();
      do_start(3);
      wait_done("stuck", 200);
      idle(2);
      resp_mode = 1;
      checks++;
      if (task_count !== 7'd3 || tv_times.size() !== 3) begin
         errors++;
         $display("FAIL stuck_count got cnt=%0d tv=%0d exp cnt=3 tv=3",
                  task_count, tv_times.size());
      end
      // Guard 2 + one WAIT cycle + fetch/decode/issue: 6 cycles per task.
      if (tv_times.size() == 3) begin
         for (int i = 1; i < 3; i++) begin
            checks++;
            if (tv_times[i] - tv_times[i-1] !== 60) begin
               errors++;
               $display("FAIL stuck_spacing%0d got %0t exp 60", i, tv_times[i] - tv_times[i-1]);
            end
         end
      end
   endtask

   task automatic test_illegal();
      write_desc(0, 3'b100, 29'd11);
      write_desc(1, 3'b011, 29'd13);
      exp_q.push_back({3'b100, 29'd11});
      clear_stats();
      do_start(3);
      wait_done("illegal", 200);
      idle(3);
      checks++;
      if (err_illegal !== 1'b1 || err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL illegal_flags got ill=%b to=%b exp ill=1 to=0", err_illegal, err_timeout);
      end
      checks++;
      if (task_count !== 7'd1 || tv_count !== 1 || done_count !== 1) begin
         errors++;
         $display("FAIL illegal_counts got cnt=%0d tv=%0d done=%0d exp 1 1 1",
                  task_count, tv_count, done_count);
      end
      checks++;
      if ({recv_enable, send_enable, conv_start, task_cfg} !== {3'b100, 29'd11}) begin
         errors++;
         $display("FAIL illegal_hold got %h exp %h",
                  {recv_enable, send_enable, conv_start, task_cfg}, {3'b100, 29'd11});
      end
   endtask

   task automatic test_timeout();
      write_desc(0, 3'b010, 29'd21);
      exp_q.push_back({3'b010, 29'd21});
      resp_mode = 0;
      clear_stats();
      do_start(1);
      wait_done("timeout", 200);
      idle(2);
      checks++;
      if (err_timeout !== 1'b1 || err_illegal !== 1'b0 || task_count !== 7'd0) begin
         errors++;
         $display("FAIL timeout_flags got to=%b ill=%b cnt=%0d exp to=1 ill=0 cnt=0",
                  err_timeout, err_illegal, task_count);
      end
      // 2 guard cycles + 16 WAIT cycles + FIN after the task_valid cycle.
      checks++;
      if (done_t - tv_first_t !== 190 || done_count !== 1) begin
         errors++;
         $display("FAIL timeout_latency got %0t/%0d exp 190/1", done_t - tv_first_t, done_count);
      end
      exp_q.push_back({3'b010, 29'd21});
      resp_mode = 1;
      clear_stats();
      do_start(1);
      @(negedge clk);
      checks++;
      if (err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clear got %b exp 0", err_timeout);
      end
      wait_done("timeout_rerun", 200);
      idle(2);
      checks++;
      if (task_count !== 7'd1 || err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_rerun got cnt=%0d to=%b exp cnt=1 to=0", task_count, err_timeout);
      end
   endtask

   task automatic test_back_to_back();
      clear_stats();
      do_start(0);
      wait_done("len0", 20);
      idle(2);
      checks++;
      if (done_t !== t_start + 15 || tv_count !== 0) begin
         errors++;
         $display("FAIL len0 got dt=%0t tv=%0d exp dt=15 tv=0", done_t - t_start, tv_count);
      end
      write_desc(0, 3'b100, 29'd31);
      write_desc(1, 3'b101, 29'd33);
      exp_q.push_back({3'b100, 29'd31});
      exp_q.push_back({3'b101, 29'd33});
      clear_stats();
      do_start(2);
      idle(1);
      // Start and write while busy: both must be ignored.
      start        = 1'b1;
      prog_len     = 7'd5;
      prog_wr_en   = 1'b1;
      prog_wr_addr = 6'd1;
      prog_wr_data = {29'd99, 3'b001};
      @(posedge clk);
      #1;
      start      = 1'b0;
      prog_wr_en = 1'b0;
      wait_done("busy_run", 200);
      idle(3);
      checks++;
      if (tv_count !== 2 || done_count !== 1 || task_count !== 7'd2) begin
         errors++;
         $display("FAIL busy_start got tv=%0d done=%0d cnt=%0d exp 2 1 2",
                  tv_count, done_count, task_count);
      end
      exp_q.push_back({3'b100, 29'd31});
      exp_q.push_back({3'b101, 29'd33});
      clear_stats();
      do_start(2);
      wait_done("ram_check", 200);
      idle(2);
      checks++;
      if (exp_q.size() !== 0 || tv_count !== 2) begin
         errors++;
         $display("FAIL busy_write got left=%0d tv=%0d exp left=0 tv=2", exp_q.size(), tv_count);
      end
   endtask

   task automatic test_reset_mid();
      write_desc(0, 3'b100, 29'd41);
      exp_q.push_back({3'b100, 29'd41});
      resp_mode = 0;
      clear_stats();
      do_start(1);
      idle(8);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy, task_valid, recv_enable, send_enable, conv_start, task_cfg} !== '0) begin
         errors++;
         $display("FAIL reset_mid got %h exp 0",
                  {busy, task_valid, recv_enable, send_enable, conv_start, task_cfg});
      end
      @(posedge clk);
      #1 rst = 1'b0;
      resp_mode = 1;
      exp_q.delete();
      write_desc(0, 3'b001, 29'd43);
      exp_q.push_back({3'b001, 29'd43});
      clear_stats();
      do_start(1);
      wait_done("post_reset", 200);
      idle(2);
      checks++;
      if (task_count !== 7'd1 || tv_count !== 1 || err_illegal !== 1'b0 || err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL post_reset got cnt=%0d tv=%0d ill=%b to=%b exp 1 1 0 0",
                  task_count, tv_count, err_illegal, err_timeout);
      end
   endtask

   initial begin
      rst          = 1'b1;
      prog_wr_en   = 1'b0;
      prog_wr_addr = '0;
      prog_wr_data = '0;
      prog_len     = '0;
      start        = 1'b0;
      clear_stats();
      test_reset();
      test_basic();
      test_stuck_done();
      test_illegal();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit got no finish exp finish before 200000");
      $fatal(1);
   end

endmodule

// File: doc/task_sequencer.md
Name: task_sequencer

Overview:
- Upstream stage of the recv/send/conv control block; owns the layer program.
- Holds a small descriptor RAM, loaded by the host while idle.
- On start, walks descriptors 0..prog_len-1. For each one it drives the task enables and task_cfg, pulses task_valid, then waits for ap_done before fetching the next.
- Flags illegal task codes and hung tasks (watchdog) and aborts the program on either.

Parameters:
- DEPTH, 64, number of descriptor entries (power of two).
- AW, 6, address width, log2(DEPTH).
- CFG_W, 29, width of per-task configuration field.
- GUARD_CYC, 2, cycles after task_valid during which ap_done is ignored (stale-done mask).
- TIMEOUT, 2^20-1, max WAIT cycles before watchdog abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- prog_wr_en  in  1  descriptor write strobe, honoured only in IDLE
- prog_wr_addr  in  AW  descriptor write address
- prog_wr_data  in  CFG_W+3  descriptor, [2:0]={recv,send,conv} code, [CFG_W+2:3]=cfg
- prog_len  in  AW+1  descriptor count, sampled on start
- start  in  1  one-cycle start pulse, ignored unless IDLE
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at program end (normal or abort)
- err_illegal  out  1  sticky, illegal code fetched; cleared by next accepted start
- err_timeout  out  1  sticky, watchdog fired; cleared by next accepted start
- task_count  out  AW+1  tasks completed in current/last run
- task_valid  out  1  one-cycle pulse, new task presented
- recv_enable  out  1  task code bit 2, held stable between task_valid pulses
- send_enable  out  1  task code bit 1, held stable
- conv_start  out  1  task code bit 0, held stable
- task_cfg  out  CFG_W  cfg field of current task, held stable
- ap_done  in  1  level, high when downstream task finished; cleared by downstream on task_valid

Behaviour:
- Reset (async): state=IDLE. All outputs 0, including busy, done, both err flags, task_count, task_valid, the enables and task_cfg. Pointer=0. RAM contents are undefined after reset.
- RAM: one write port, one synchronous read port. Read data is valid the cycle after the address is presented.
- Write rules: writes are ignored when busy. Write and start in the same IDLE cycle: the write lands, then start proceeds.
- States and transitions:
  - IDLE: start → clear both errs and task_count, latch len=prog_len, ptr=0. If len==0 go to FIN, else FETCH.
  - FETCH: present RAM address ptr (1 cycle) → DECODE.
  - DECODE: legal codes are 100, 010, 001, 101. Legal → register the enables and task_cfg, go to ISSUE. Illegal → set err_illegal, go to FIN; the enables keep their previous values.
  - ISSUE: task_valid=1 for exactly this cycle → GUARD, guard counter=GUARD_CYC.
  - GUARD: decrement the counter, ignore ap_done; at 0 → WAIT. Watchdog counter is cleared on entry.
  - WAIT: ap_done==1 → task_count+1, ptr+1; if ptr+1==len go to FIN, else FETCH. If TIMEOUT≠0 and the watchdog reaches TIMEOUT → set err_timeout, go to FIN.
  - FIN: done=1 for one cycle → IDLE.
- Latency:
  - Start sampled at edge k → task_valid high in the cycle after edge k+3.
  - ap_done sampled high in WAIT → next task_valid 4 cycles later.
  - len==0: done is high in the cycle after edge k+1.
- Simultaneous events:
  - ap_done and the watchdog limit in the same WAIT cycle → ap_done wins; no error.
  - start while busy → ignored, no side effects.
- ptr and task_count are AW+1 bits wide; prog_len > DEPTH is clamped to DEPTH.
- Reset mid-run: immediate return to IDLE with all outputs 0. Downstream is also reset by the same rst.

Test Plan:
- Load 3 descriptors {100,cfg=5},{001,cfg=7},{010,cfg=9}, prog_len=3, start; answer each task_valid with ap_done 5 cycles later → three task_valid pulses with matching enables/cfg; done pulse once; task_count=3; errs 0; first task_valid 4 cycles after start edge.
- Drive ap_done=1 continuously, including the GUARD window → each task still waits through GUARD_CYC=2 before advancing; no task is skipped; task_count=len.
- Descriptor 1 code=011 → task 0 runs, then err_illegal=1 and done pulse; task_count=1; task_valid pulsed once only.
- TIMEOUT=16, never assert ap_done → err_timeout=1 after 16 WAIT cycles, done pulse; next start clears err_timeout.
- prog_len=0 → done pulse 2 cycles after start, no task_valid; start pulsed again while busy during a 2-task run → ignored; write while busy → RAM unchanged.
- Assert rst mid-WAIT → outputs go to 0 immediately (async); a fresh start after reset runs normally.
